// File: rtl/fpadd_pkg.sv
// Shared types and constants for the floating-point adder issuer.
// Covers the issuer FSM state encoding and the IEEE-754 single-precision word format.
package fpadd_pkg;

    localparam int FP_W = 32;
    localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC00000;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        ARM,
        WAIT,
        HOLD
    } state_e;

endpackage

// File: rtl/fpadd_issue_fifo.sv
// Operand FIFO for the adder issuer: DEPTH x W storage, extra pointer MSB separates full from empty.
// The head entry is presented combinationally so the issuer can latch it on the issue edge.
module fpadd_issue_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push_i,
    input  logic [W-1:0] wr_data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q;
    logic [AW:0]  rd_ptr_q;
    logic         do_push;
    logic         do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
        end
    end

    // Storage has no reset: stale words are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

endmodule

// File: rtl/fpadd_issuer.sv
// Issues buffered operand pairs one at a time to a start/done FP adder and returns results
// on a valid/ready stream; a watchdog substitutes a flagged QNaN if the adder never finishes.
module fpadd_issuer
    import fpadd_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [FP_W-1:0] in_a,
    input  logic [FP_W-1:0] in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [FP_W-1:0] out_sum,
    output logic            out_err,
    output logic            fp_start,
    output logic [FP_W-1:0] fp_a,
    output logic [FP_W-1:0] fp_b,
    input  logic [FP_W-1:0] fp_sum,
    input  logic            fp_done,
    output logic            busy
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    state_e              state_q;
    logic [CW-1:0]       cnt_q;
    logic                fp_start_q;
    logic [FP_W-1:0]     fp_a_q;
    logic [FP_W-1:0]     fp_b_q;
    logic                out_valid_q;
    logic [FP_W-1:0]     out_sum_q;
    logic                out_err_q;

    logic                fifo_full;
    logic                fifo_empty;
    logic [2*FP_W-1:0]   fifo_head;
    logic                issue_go;

    fpadd_issue_fifo #(
        .DEPTH (DEPTH),
        .W     (2*FP_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push_i    (in_valid),
        .wr_data_i ({in_a, in_b}),
        .pop_i     (state_q == ISSUE),
        .head_o    (fifo_head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    // A new operation may start from IDLE, or straight out of HOLD as the result is taken.
    assign issue_go = !fifo_empty &&
                      ((state_q == IDLE) || ((state_q == HOLD) && out_ready));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            fp_start_q  <= 1'b0;
            fp_a_q      <= '0;
            fp_b_q      <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_err_q   <= 1'b0;
        end else begin
            fp_start_q <= 1'b0;
            if (issue_go) begin
                fp_start_q <= 1'b1;
                fp_a_q     <= fifo_head[2*FP_W-1:FP_W];
                fp_b_q     <= fifo_head[FP_W-1:0];
            end
            case (state_q)
                IDLE: begin
                    if (issue_go) begin
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    state_q <= ARM;
                end
                // fp_done may still reflect the previous operation here, so it is not looked at.
                ARM: begin
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (fp_done) begin
                        out_sum_q   <= fp_sum;
                        out_err_q   <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= HOLD;
                    end else if (cnt_q == CNT_MAX) begin
                        out_sum_q   <= FP_QNAN;
                        out_err_q   <= 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= HOLD;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= issue_go ? ISSUE : IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = !fifo_full;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_err   = out_err_q;
    assign fp_start  = fp_start_q;
    assign fp_a      = fp_a_q;
    assign fp_b      = fp_b_q;
    assign busy      = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_fpadd_issuer.sv
// Self-checking bench for fpadd_issuer: behavioural start/done adder, result scoreboard,
// and one task per scenario (reset, single op, back-to-back, backpressure, stale done, watchdog).
module tb_fpadd_issuer;

    localparam int TIMEOUT = 64;
    localparam logic [31:0] QNAN = 32'h7FC00000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_sum;
    logic        out_err;
    logic        fp_start;
    logic [31:0] fp_a;
    logic [31:0] fp_b;
    logic [31:0] fp_sum = '0;
    logic        fp_done = 1'b0;
    logic        busy;

    fpadd_issuer #(.DEPTH(4), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_err   (out_err),
        .fp_start  (fp_start),
        .fp_a      (fp_a),
        .fp_b      (fp_b),
        .fp_sum    (fp_sum),
        .fp_done   (fp_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Exact single-precision sums: 1+2, 2+2, 1.5+2.5, 3+4, 0.5+0.25, -1+1, 10-4, 1+1
    logic [31:0] tab_a [8] = '{32'h3F800000, 32'h40000000, 32'h3FC00000, 32'h40400000,
                               32'h3F000000, 32'hBF800000, 32'h41200000, 32'h3F800000};
    logic [31:0] tab_b [8] = '{32'h40000000, 32'h40000000, 32'h40200000, 32'h40800000,
                               32'h3E800000, 32'h3F800000, 32'hC0800000, 32'h3F800000};
    logic [31:0] tab_s [8] = '{32'h40400000, 32'h40800000, 32'h40800000, 32'h40E00000,
                               32'h3F400000, 32'h00000000, 32'h40C00000, 32'h40000000};

    typedef struct packed {
        logic [31:0] sum;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_res = 0;
    int   cyc = 0;
    int   start_cnt = 0;
    int   last_start_cyc = 0;
    int   rise_cnt = 0;
    int   rise_cyc = 0;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] lookup(input logic [31:0] a, input logic [31:0] b);
        lookup = 32'hDEADBEEF;
        for (int i = 0; i < 8; i++) begin
            if (tab_a[i] == a && tab_b[i] == b) lookup = tab_s[i];
        end
    endfunction

    // Behavioural adder: done is a level held until the next start; stale mode keeps the
    // old done through the ARM cycle, hang mode never finishes.
    int          lat_m = 10;
    bit          hang_m = 0;
    bit          stale_m = 0;
    bit          run_m = 0;
    int          cnt_m = 0;
    logic [31:0] opa_m = '0;
    logic [31:0] opb_m = '0;

    always @(negedge clk) begin
        if (fp_start) begin
            run_m = 1;
            cnt_m = 0;
            opa_m = fp_a;
            opb_m = fp_b;
            if (!stale_m) fp_done = 1'b0;
        end else if (run_m) begin
            cnt_m++;
            if (stale_m && cnt_m == 2) fp_done = 1'b0;
            if (!hang_m && cnt_m == lat_m) begin
                fp_done = 1'b1;
                fp_sum  = lookup(opa_m, opb_m);
                run_m   = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (fp_start) begin
            start_cnt++;
            last_start_cyc = cyc;
        end
        if (out_valid && !prev_valid) begin
            rise_cnt++;
            rise_cyc = cyc;
        end
        prev_valid = out_valid;
    end

    // Scoreboard: every accepted result is popped and compared in order.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && out_valid && out_ready) begin
            n_res++;
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_result: got sum=%h err=%b, required no result", out_sum, out_err);
            end else begin
                e = sb.pop_front();
                if (out_sum !== e.sum || out_err !== e.err) begin
                    n_fail++;
                    $display("FAIL result_%0d: got sum=%h err=%b, required sum=%h err=%b",
                             n_res, out_sum, out_err, e.sum, e.err);
                end else begin
                    $display("result %0d: sum=%h err=%b matches", n_res, out_sum, out_err);
                end
            end
        end
    end

    task automatic push(input int idx, input bit err, output bit ok);
        exp_t e;
        ok = 0;
        in_valid = 1'b1;
        in_a = tab_a[idx];
        in_b = tab_b[idx];
        for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                e.sum = err ? QNAN : tab_s[idx];
                e.err = err;
                sb.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int maxc, output bit ok);
        ok = 0;
        for (int t = 0; t < maxc; t++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy && !out_valid) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int maxc, output bit ok);
        ok = 0;
        for (int t = 0; t < maxc && !ok; t++) begin
            @(negedge clk);
            if (out_valid) ok = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({in_ready, out_valid, out_err, fp_start, busy} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_flags: got rdy/vld/err/start/busy=%b, required 10000",
                     {in_ready, out_valid, out_err, fp_start, busy});
        end
        n_checks++;
        if (out_sum !== 32'h0 || fp_a !== 32'h0 || fp_b !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_words: got sum=%h a=%h b=%h, required all zero", out_sum, fp_a, fp_b);
        end
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL after_reset: got in_ready=%b busy=%b, required 1 0", in_ready, busy);
        end
    endtask

    task automatic test_single;
        bit ok;
        int push_cyc;
        int s0;
        lat_m = 10;
        s0 = start_cnt;
        push(0, 0, ok);
        push_cyc = cyc;
        wait_drain(200, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL single_drain: got timeout, required completion");
        end
        n_checks++;
        if (start_cnt - s0 !== 1) begin
            n_fail++;
            $display("FAIL single_start_cycles: got %0d start cycles, required 1", start_cnt - s0);
        end
        n_checks++;
        if (last_start_cyc !== push_cyc + 1) begin
            n_fail++;
            $display("FAIL single_start_latency: got cycle %0d, required %0d", last_start_cyc, push_cyc + 1);
        end
        n_checks++;
        if (rise_cyc - last_start_cyc !== 11) begin
            n_fail++;
            $display("FAIL single_valid_latency: got %0d cycles after start, required 11",
                     rise_cyc - last_start_cyc);
        end
        n_checks++;
        if (fp_a !== 32'h3F800000 || fp_b !== 32'h40000000) begin
            n_fail++;
            $display("FAIL single_operands: got a=%h b=%h, required 3f800000 40000000", fp_a, fp_b);
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        int s0;
        int seq [4] = '{1, 3, 4, 6};
        lat_m = 3;
        s0 = start_cnt;
        out_ready = 1'b0;
        push(0, 0, ok);
        wait_valid(100, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL b2b_first_valid: got timeout, required out_valid");
        end
        for (int i = 0; i < 4; i++) push(seq[i], 0, ok);
        n_checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_full: got in_ready=%b busy=%b, required 0 1", in_ready, busy);
        end
        out_ready = 1'b1;
        wait_drain(500, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL b2b_drain: got timeout, required completion");
        end
        n_checks++;
        if (start_cnt - s0 !== 5) begin
            n_fail++;
            $display("FAIL b2b_starts: got %0d, required 5", start_cnt - s0);
        end
    endtask

    task automatic test_backpressure;
        bit ok;
        int s0;
        int rc;
        logic [31:0] held;
        lat_m = 4;
        out_ready = 1'b0;
        push(3, 0, ok);
        push(4, 0, ok);
        wait_valid(100, ok);
        held = out_sum;
        s0 = start_cnt;
        n_checks++;
        if (!ok || held !== 32'h40E00000) begin
            n_fail++;
            $display("FAIL bp_first: got sum=%h valid_ok=%0d, required 40e00000 1", held, ok);
        end
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            n_checks++;
            if (out_sum !== held || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: got sum=%h valid=%b, required %h 1", t, out_sum, out_valid, held);
            end
        end
        n_checks++;
        if (start_cnt !== s0) begin
            n_fail++;
            $display("FAIL bp_no_start: got %0d starts during hold, required 0", start_cnt - s0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        rc = cyc;
        wait_drain(200, ok);
        n_checks++;
        if (!ok || last_start_cyc !== rc + 1) begin
            n_fail++;
            $display("FAIL bp_release_issue: got start cycle %0d, required %0d", last_start_cyc, rc + 1);
        end
    endtask

    task automatic test_stale_done;
        bit ok;
        lat_m = 6;
        stale_m = 1;
        push(5, 0, ok);
        wait_drain(200, ok);
        stale_m = 0;
        n_checks++;
        if (!ok || out_sum !== 32'h00000000 || out_err !== 1'b0) begin
            n_fail++;
            $display("FAIL stale_done: got sum=%h err=%b, required 00000000 0", out_sum, out_err);
        end
    endtask

    task automatic test_watchdog;
        bit ok;
        hang_m = 1;
        push(2, 1, ok);
        wait_drain(300, ok);
        n_checks++;
        if (!ok || rise_cyc - last_start_cyc !== TIMEOUT + 2) begin
            n_fail++;
            $display("FAIL watchdog_latency: got %0d cycles after issue, required %0d",
                     rise_cyc - last_start_cyc, TIMEOUT + 2);
        end
        n_checks++;
        if (out_sum !== QNAN || out_err !== 1'b1) begin
            n_fail++;
            $display("FAIL watchdog_result: got sum=%h err=%b, required 7fc00000 1", out_sum, out_err);
        end
        hang_m = 0;
        lat_m = 5;
        push(7, 0, ok);
        wait_drain(200, ok);
        n_checks++;
        if (!ok || out_sum !== 32'h40000000 || out_err !== 1'b0) begin
            n_fail++;
            $display("FAIL watchdog_recover: got sum=%h err=%b, required 40000000 0", out_sum, out_err);
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        int s0;
        int r0;
        hang_m = 1;
        out_ready = 1'b1;
        push(1, 1, ok);
        push(3, 0, ok);
        push(4, 0, ok);
        repeat (5) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        sb.delete();
        n_checks++;
        if ({in_ready, out_valid, out_err, fp_start, busy} !== 5'b10000) begin
            n_fail++;
            $display("FAIL midreset_flags: got rdy/vld/err/start/busy=%b, required 10000",
                     {in_ready, out_valid, out_err, fp_start, busy});
        end
        n_checks++;
        if (out_sum !== 32'h0 || fp_a !== 32'h0 || fp_b !== 32'h0) begin
            n_fail++;
            $display("FAIL midreset_words: got sum=%h a=%h b=%h, required all zero", out_sum, fp_a, fp_b);
        end
        hang_m = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        s0 = start_cnt;
        r0 = rise_cnt;
        repeat (40) @(posedge clk);
        #1;
        n_checks++;
        if (start_cnt !== s0 || rise_cnt !== r0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_quiet: got starts=%0d results=%0d busy=%b, required 0 0 0",
                     start_cnt - s0, rise_cnt - r0, busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_stale_done();
        test_watchdog();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
